// File: rtl/spi_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : spi_dac_multi
//  Description : NCH-channel serial DAC driver sharing one serial clock.
//                Each channel has a word FIFO with valid/ready, its own data
//                line and frame strobe, and an optional repeat mode that
//                re-sends the last word when the FIFO runs dry.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_dac_multi #(
    parameter int NCH      = 2,
    parameter int DW       = 8,
    parameter int DEPTH    = 4,
    parameter int CLK_DIV  = 2,
    parameter int IDLE_CYC = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NCH*DW-1:0]                data_in,
    input  logic [NCH-1:0]                   valid_in,
    output logic [NCH-1:0]                   ready_out,
    input  logic [NCH-1:0]                   repeat_en,
    output logic                             sclk,
    output logic [NCH-1:0]                   dout,
    output logic [NCH-1:0]                   sync_n,
    output logic [NCH-1:0]                   busy,
    output logic [NCH*($clog2(DEPTH)+1)-1:0] level
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_LW    = c_AW + 1;
    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W = $clog2(DW);
    localparam int c_GAP_W = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DW - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(IDLE_CYC - 1);
    localparam logic [c_LW-1:0]    c_FULL     = c_LW'(DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    logic [c_DIV_W-1:0] r_div;
    logic               r_sclk;
    logic               w_rise;

    // Shared divider: toggles sclk every CLK_DIV clk cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (r_div == c_DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // All channel activity is keyed to the 0->1 toggle of sclk
    assign w_rise = (r_div == c_DIV_LAST) && !r_sclk;
    assign sclk   = r_sclk;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            logic [DW-1:0]      r_mem [DEPTH];
            logic [c_AW-1:0]    r_wptr;
            logic [c_AW-1:0]    r_rptr;
            logic [c_LW-1:0]    r_level;
            logic [1:0]         r_state;
            logic [1:0]         w_state_nxt;
            logic [DW-1:0]      r_shift;
            logic [DW-1:0]      r_last;
            logic               r_has_last;
            logic [c_BIT_W-1:0] r_bitcnt;
            logic [c_GAP_W-1:0] r_gapcnt;
            logic               r_sync_n;
            logic               r_dout;
            logic [DW-1:0]      w_din;
            logic [DW-1:0]      w_word;
            logic               w_full;
            logic               w_fifo_ne;
            logic               w_work;
            logic               w_push;
            logic               w_pop;
            logic               w_start;

            // FIFO contents win over the repeat word whenever both exist
            assign w_din     = data_in[g*DW +: DW];
            assign w_full    = (r_level == c_FULL);
            assign w_fifo_ne = (r_level != '0);
            assign w_work    = w_fifo_ne | (repeat_en[g] & r_has_last);
            assign w_word    = w_fifo_ne ? r_mem[r_rptr] : r_last;
            assign w_push    = valid_in[g] & ~w_full;
            assign w_start   = w_rise & w_work &
                               ((r_state == c_ST_IDLE) |
                                ((r_state == c_ST_GAP) & (r_gapcnt == '0)));
            assign w_pop     = w_start & w_fifo_ne;

            // Next-state decode, only advancing on sclk rise events
            always_comb begin
                w_state_nxt = r_state;
                if (w_rise) begin
                    case (r_state)
                        c_ST_IDLE:  if (w_work) w_state_nxt = c_ST_SHIFT;
                        c_ST_SHIFT: if (r_bitcnt == '0) w_state_nxt = c_ST_GAP;
                        c_ST_GAP:   if (r_gapcnt == '0)
                                        w_state_nxt = w_work ? c_ST_SHIFT : c_ST_IDLE;
                        default:    w_state_nxt = c_ST_IDLE;
                    endcase
                end
            end

            // State register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_state <= c_ST_IDLE;
                else       r_state <= w_state_nxt;
            end

            // FIFO storage; contents need no reset since level gates reads
            always_ff @(posedge clk) begin
                if (w_push) r_mem[r_wptr] <= w_din;
            end

            // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_level <= '0;
                end else begin
                    if (w_push) r_wptr <= r_wptr + 1'b1;
                    if (w_pop)  r_rptr <= r_rptr + 1'b1;
                    if (w_push && !w_pop)      r_level <= r_level + 1'b1;
                    else if (w_pop && !w_push) r_level <= r_level - 1'b1;
                end
            end

            // Frame datapath: load, shift out MSB first, then hold the gap
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_shift    <= '0;
                    r_last     <= '0;
                    r_has_last <= 1'b0;
                    r_bitcnt   <= '0;
                    r_gapcnt   <= '0;
                    r_sync_n   <= 1'b1;
                    r_dout     <= 1'b0;
                end else if (w_start) begin
                    r_shift    <= w_word;
                    r_last     <= w_word;
                    r_has_last <= 1'b1;
                    r_sync_n   <= 1'b0;
                    r_dout     <= w_word[DW-1];
                    r_bitcnt   <= c_BIT_LAST;
                end else if (w_rise && (r_state == c_ST_SHIFT)) begin
                    if (r_bitcnt == '0) begin
                        r_sync_n <= 1'b1;
                        r_dout   <= 1'b0;
                        r_gapcnt <= c_GAP_LAST;
                    end else begin
                        r_shift  <= r_shift << 1;
                        r_dout   <= r_shift[DW-2];
                        r_bitcnt <= r_bitcnt - 1'b1;
                    end
                end else if (w_rise && (r_state == c_ST_GAP) && (r_gapcnt != '0)) begin
                    r_gapcnt <= r_gapcnt - 1'b1;
                end
            end

            assign ready_out[g]            = ~w_full;
            assign dout[g]                 = r_dout;
            assign sync_n[g]               = r_sync_n;
            assign busy[g]                 = (r_state != c_ST_IDLE);
            assign level[g*c_LW +: c_LW]   = r_level;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_dac_multi
//  Description : Self-checking bench for spi_dac_multi. A negedge monitor
//                decodes DAC frames off the pins; the stimulus keeps its own
//                list of accepted words and compares decoded frames to it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_dac_multi;
    localparam int NCH       = 2;
    localparam int DW        = 8;
    localparam int DEPTH     = 4;
    localparam int CLK_DIV   = 2;
    localparam int IDLE_CYC  = 1;
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int FRAME_CLK = DW * 2 * CLK_DIV;
    localparam int GAP_CLK   = IDLE_CYC * 2 * CLK_DIV;
    localparam int MAXF      = 512;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NCH*DW-1:0]   data_in = '0;
    logic [NCH-1:0]      valid_in = '0;
    logic [NCH-1:0]      ready_out;
    logic [NCH-1:0]      repeat_en = '0;
    logic                sclk;
    logic [NCH-1:0]      dout;
    logic [NCH-1:0]      sync_n;
    logic [NCH-1:0]      busy;
    logic [NCH*LW-1:0]   level;

    spi_dac_multi #(
        .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .IDLE_CYC(IDLE_CYC)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .repeat_en(repeat_en), .sclk(sclk), .dout(dout),
        .sync_n(sync_n), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Monitor records: decoded word, low length, bit count, start edge, gap
    logic [DW-1:0] obs_w   [NCH][MAXF];
    int            obs_len [NCH][MAXF];
    int            obs_bits[NCH][MAXF];
    int            obs_t   [NCH][MAXF];
    int            obs_gap [NCH][MAXF];
    int            obs_n   [NCH];
    logic          in_fr   [NCH];
    logic          had_end [NCH];
    int            lowcnt  [NCH];
    int            hcnt    [NCH];
    int            nb      [NCH];
    int            st_t    [NCH];
    int            st_gap  [NCH];
    logic [DW-1:0] cap     [NCH];
    logic          prev_sclk = 1'b0;

    // Reference model: words accepted per channel, and how far checking got
    logic [DW-1:0] exp_w [NCH][MAXF];
    int            exp_n [NCH];
    int            ptr   [NCH];

    initial begin
        for (int c = 0; c < NCH; c++) begin
            obs_n[c] = 0; in_fr[c] = 1'b0; had_end[c] = 1'b0; lowcnt[c] = 0;
            hcnt[c] = 0; nb[c] = 0; st_t[c] = 0; st_gap[c] = -1; cap[c] = '0;
            exp_n[c] = 0; ptr[c] = 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Frame decoder: DAC samples dout on the sclk falling edge while sync_n low
    always @(negedge clk) begin
        prev_sclk <= sclk;
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                in_fr[c]   <= 1'b0;
                had_end[c] <= 1'b0;
            end else if (in_fr[c]) begin
                if (sync_n[c]) begin
                    if (obs_n[c] < MAXF) begin
                        obs_w[c][obs_n[c]]    <= cap[c];
                        obs_len[c][obs_n[c]]  <= lowcnt[c];
                        obs_bits[c][obs_n[c]] <= nb[c];
                        obs_t[c][obs_n[c]]    <= st_t[c];
                        obs_gap[c][obs_n[c]]  <= st_gap[c];
                    end
                    obs_n[c]   <= obs_n[c] + 1;
                    in_fr[c]   <= 1'b0;
                    had_end[c] <= 1'b1;
                    hcnt[c]    <= 1;
                end else begin
                    lowcnt[c] <= lowcnt[c] + 1;
                    if (prev_sclk && !sclk) begin
                        cap[c] <= {cap[c][DW-2:0], dout[c]};
                        nb[c]  <= nb[c] + 1;
                    end
                end
            end else if (!sync_n[c]) begin
                in_fr[c]  <= 1'b1;
                lowcnt[c] <= 1;
                cap[c]    <= '0;
                nb[c]     <= 0;
                st_t[c]   <= cyc;
                st_gap[c] <= had_end[c] ? hcnt[c] : -1;
            end else begin
                hcnt[c] <= hcnt[c] + 1;
            end
        end
    end

    function automatic int lvl(input int c);
        return int'(level[c*LW +: LW]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake cycle; channels in mask that are ready get their word.
    // Called and returns 1 time unit after a rising edge.
    task automatic push_mask(input logic [NCH-1:0] mask, input logic [DW-1:0] w0,
                             input logic [DW-1:0] w1, output int pcyc);
        logic [NCH-1:0] acc;
        acc      = mask & ready_out;
        data_in  = {w1, w0};
        valid_in = mask;
        tick();
        pcyc = cyc;
        for (int c = 0; c < NCH; c++) begin
            if (acc[c] && exp_n[c] < MAXF) begin
                exp_w[c][exp_n[c]] = (c == 0) ? w0 : w1;
                exp_n[c]++;
            end
        end
        valid_in = '0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        logic tmo;
        n = 0;
        tmo = 1'b0;
        while (!(busy == '0 && level == '0 && sync_n == '1)) begin
            tick();
            n++;
            if (n > 20000) begin tmo = 1'b1; break; end
        end
        chk({tag, "_drain_timeout"}, 32'(tmo), 32'd0);
        repeat (2) tick();
    endtask

    // Leaves time at 1 unit after the edge three cycles past an sclk rise,
    // so the next handshake lands exactly on a rise event.
    task automatic align_rise();
        logic last;
        int n;
        last = sclk;
        n = 0;
        forever begin
            tick();
            n++;
            if ((sclk && !last) || n > 100) break;
            last = sclk;
        end
        repeat (2 * CLK_DIV - 1) tick();
    endtask

    task automatic wait_frames(input int c, input int target, input string tag);
        int n;
        logic tmo;
        n = 0;
        tmo = 1'b0;
        while (obs_n[c] < target) begin
            tick();
            n++;
            if (n > 5000) begin tmo = 1'b1; break; end
        end
        chk({tag, "_frames_timeout"}, 32'(tmo), 32'd0);
    endtask

    task automatic compare_all(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s_ch%0d_count", tag, c), 32'(obs_n[c]), 32'(exp_n[c]));
            for (int i = ptr[c]; i < obs_n[c] && i < exp_n[c]; i++) begin
                chk($sformatf("%s_ch%0d_word%0d", tag, c, i), 32'(obs_w[c][i]), 32'(exp_w[c][i]));
                chk($sformatf("%s_ch%0d_len%0d", tag, c, i), 32'(obs_len[c][i]), 32'(FRAME_CLK));
                chk($sformatf("%s_ch%0d_bits%0d", tag, c, i), 32'(obs_bits[c][i]), 32'(DW));
            end
            ptr[c]   = obs_n[c];
            exp_n[c] = obs_n[c];
        end
    endtask

    initial begin
        int pc;
        int p7e;
        int base;
        int n7e;
        int n3c;
        logic [DW-1:0] ew;

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_sync_n", 32'(sync_n), 32'h3);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_ready", 32'(ready_out), 32'h3);
        chk("rst_sclk", 32'(sclk), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // ---- single word on ch0 ----
        push_mask(2'b01, 8'hA5, 8'h00, pc);
        wait_drain("single");
        chk("single_latency_ok", 32'((st_t[0] - pc) >= 1 && (st_t[0] - pc) <= 2*CLK_DIV+1), 32'd1);
        chk("single_ch1_idle", 32'(obs_n[1]), 32'd0);
        compare_all("single");

        // ---- back-to-back on ch1 ----
        align_rise();
        base = obs_n[1];
        push_mask(2'b10, 8'h00, 8'h01, pc);
        push_mask(2'b10, 8'h00, 8'h02, pc);
        push_mask(2'b10, 8'h00, 8'h03, pc);
        chk("b2b_level_peak", 32'(lvl(1)), 32'd3);
        wait_frames(1, base + 3, "b2b");
        chk("b2b_busy_in_gap", 32'(busy[1]), 32'd1);
        repeat (2*CLK_DIV*IDLE_CYC - 1) tick();
        chk("b2b_busy_after_gap", 32'(busy[1]), 32'd0);
        chk("b2b_gap2", 32'(obs_gap[1][base+1]), 32'(GAP_CLK));
        chk("b2b_gap3", 32'(obs_gap[1][base+2]), 32'(GAP_CLK));
        wait_drain("b2b");
        compare_all("b2b");

        // ---- full FIFO on ch0 ----
        align_rise();
        push_mask(2'b01, 8'h11, 8'h00, pc);
        push_mask(2'b01, 8'h22, 8'h00, pc);
        push_mask(2'b01, 8'h33, 8'h00, pc);
        push_mask(2'b01, 8'h44, 8'h00, pc);
        chk("full_level", 32'(lvl(0)), 32'(DEPTH));
        chk("full_ready", 32'(ready_out[0]), 32'd0);
        push_mask(2'b01, 8'h55, 8'h00, pc);   // refused: FIFO still full here
        chk("full_after_pop_level", 32'(lvl(0)), 32'(DEPTH - 1));
        chk("full_after_pop_ready", 32'(ready_out[0]), 32'd1);
        push_mask(2'b01, 8'h55, 8'h00, pc);
        chk("full_refill_level", 32'(lvl(0)), 32'(DEPTH));
        wait_drain("full");
        compare_all("full");

        // ---- simultaneous channels ----
        push_mask(2'b11, 8'h5A, 8'hC3, pc);
        wait_drain("simul");
        chk("simul_start_aligned", 32'(obs_t[0][obs_n[0]-1]), 32'(obs_t[1][obs_n[1]-1]));
        chk("simul_len_equal", 32'(obs_len[0][obs_n[0]-1]), 32'(obs_len[1][obs_n[1]-1]));
        compare_all("simul");

        // ---- randomized traffic on both channels ----
        for (int k = 0; k < 40; k++) begin
            push_mask(2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom), pc);
            repeat ($urandom_range(0, 8)) tick();
        end
        wait_drain("rand");
        for (int c = 0; c < NCH; c++)
            for (int i = ptr[c] + 1; i < obs_n[c]; i++)
                chk($sformatf("rand_gap_ch%0d_%0d", c, i), 32'(obs_gap[c][i] >= GAP_CLK), 32'd1);
        compare_all("rand");

        // ---- reset in the middle of a frame ----
        push_mask(2'b01, 8'hF0, 8'h00, pc);
        begin
            int n;
            n = 0;
            while (!(in_fr[0] && nb[0] >= 4) && n < 500) begin tick(); n++; end
            chk("midrst_reached", 32'(n < 500), 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("midrst_sync_n", 32'(sync_n), 32'h3);
        chk("midrst_sclk", 32'(sclk), 32'h0);
        chk("midrst_dout", 32'(dout), 32'h0);
        chk("midrst_ready", 32'(ready_out), 32'h3);
        chk("midrst_level", 32'(level), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        for (int c = 0; c < NCH; c++) exp_n[c] = ptr[c];   // in-flight words are dropped
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (80) tick();
        compare_all("midrst_quiet");

        // ---- repeat mode: nothing to repeat right after reset ----
        repeat_en = 2'b11;
        repeat (80) tick();
        compare_all("rep_nolast");
        repeat_en = 2'b01;
        base = obs_n[0];
        push_mask(2'b01, 8'h3C, 8'h00, pc);
        wait_frames(0, base + 3, "rep3c");
        push_mask(2'b01, 8'h7E, 8'h00, p7e);
        wait_frames(0, obs_n[0] + 3, "rep7e");
        repeat_en = 2'b00;
        wait_drain("rep");
        n7e = 0;
        n3c = 0;
        for (int i = base; i < obs_n[0]; i++) begin
            ew = (obs_t[0][i] > p7e) ? 8'h7E : 8'h3C;
            if (ew == 8'h7E) n7e++; else n3c++;
            chk($sformatf("rep_word%0d", i), 32'(obs_w[0][i]), 32'(ew));
            chk($sformatf("rep_len%0d", i), 32'(obs_len[0][i]), 32'(FRAME_CLK));
            if (i > base)
                chk($sformatf("rep_gap%0d", i), 32'(obs_gap[0][i]), 32'(GAP_CLK));
        end
        chk("rep_3c_frames", 32'(n3c >= 3), 32'd1);
        chk("rep_7e_frames", 32'(n7e >= 3), 32'd1);
        chk("rep_ch1_idle", 32'(obs_n[1]), 32'(ptr[1]));
        ptr[0]   = obs_n[0];
        exp_n[0] = obs_n[0];
        repeat (80) tick();
        compare_all("rep_off_quiet");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
